// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
package mem_bus_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned TIMEOUT_DEF    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/bus_watchdog.sv
// Counts stalled BUSY cycles; expire fires on the last allowed cycle.
// TIMEOUT_CYCLES = 0 removes the counter entirely.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clear, enable};
            assign expire        = 1'b0;
        end else begin : g_enabled
            localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count;

            // clear has priority so the expiring cycle also resets the count
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable) begin
                    count <= count + CW'(1);
                end
            end

            assign expire = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single memory bus with round-robin or fixed
// priority, registered bus outputs and a hung-transaction watchdog.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_read,
    input  logic                  p0_write,
    input  logic [ADDR_WIDTH-1:0] p0_address,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_ready,
    input  logic                  p1_read,
    input  logic                  p1_write,
    input  logic [ADDR_WIDTH-1:0] p1_address,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_ready,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [DATA_WIDTH-1:0] memory_in,
    output logic                  memory_read_signal,
    output logic                  memory_write_signal,
    input  logic [DATA_WIDTH-1:0] memory_out,
    input  logic                  memory_ready,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  timeout_error
);

    state_t                state, state_next;
    logic                  last_grant, last_grant_next;
    logic [1:0]            grant_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic                  rd_next, wr_next;
    logic                  p0_req, p1_req, winner, owner, done, expire;
    logic [DATA_WIDTH-1:0] resp;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clear ((state == ST_IDLE) || done),
        .enable((state == ST_BUSY) && !memory_ready),
        .expire(expire)
    );

    assign busy = (state == ST_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            grant               <= 2'b00;
            last_grant          <= PORT_AUX;
            memory_address      <= '0;
            memory_in           <= '0;
            memory_read_signal  <= 1'b0;
            memory_write_signal <= 1'b0;
        end else begin
            state               <= state_next;
            grant               <= grant_next;
            last_grant          <= last_grant_next;
            memory_address      <= addr_next;
            memory_in           <= wdata_next;
            memory_read_signal  <= rd_next;
            memory_write_signal <= wr_next;
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        addr_next       = memory_address;
        wdata_next      = memory_in;
        rd_next         = memory_read_signal;
        wr_next         = memory_write_signal;
        p0_ready        = 1'b0;
        p1_ready        = 1'b0;
        p0_rdata        = '0;
        p1_rdata        = '0;
        timeout_error   = 1'b0;

        p0_req = p0_read | p0_write;
        p1_req = p1_read | p1_write;
        owner  = grant[1] ? PORT_AUX : PORT_CPU;
        done   = (state == ST_BUSY) && (memory_ready || expire);
        resp   = memory_ready ? memory_out : {DATA_WIDTH{1'b1}};

        // tie goes to port 0 under fixed priority, else to the port not served last
        if (p0_req && p1_req) begin
            winner = (FIXED_PRIORITY != 0) ? PORT_CPU : ~last_grant;
        end else if (p1_req) begin
            winner = PORT_AUX;
        end else begin
            winner = PORT_CPU;
        end

        case (state)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    state_next = ST_BUSY;
                    if (winner == PORT_AUX) begin
                        grant_next = 2'b10;
                        addr_next  = p1_address;
                        wdata_next = p1_wdata;
                        wr_next    = p1_write;
                        rd_next    = p1_read & ~p1_write;
                    end else begin
                        grant_next = 2'b01;
                        addr_next  = p0_address;
                        wdata_next = p0_wdata;
                        wr_next    = p0_write;
                        rd_next    = p0_read & ~p0_write;
                    end
                end
            end
            ST_BUSY: begin
                if (done) begin
                    state_next      = ST_IDLE;
                    grant_next      = 2'b00;
                    rd_next         = 1'b0;
                    wr_next         = 1'b0;
                    last_grant_next = owner;
                    timeout_error   = expire;
                    if (owner == PORT_AUX) begin
                        p1_ready = 1'b1;
                        p1_rdata = resp;
                    end else begin
                        p0_ready = 1'b1;
                        p0_rdata = resp;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; a second instance with
// fixed priority shares the stimulus.
module tb_mem_bus_arbiter;

    logic       clk, rst_n;
    logic       p0_read, p0_write, p1_read, p1_write;
    logic [7:0] p0_address, p0_wdata, p1_address, p1_wdata;
    logic [7:0] p0_rdata, p1_rdata;
    logic       p0_ready, p1_ready;
    logic [7:0] memory_address, memory_in, memory_out;
    logic       memory_read_signal, memory_write_signal, memory_ready;
    logic [1:0] grant;
    logic       busy, timeout_error;

    logic [7:0] fp_p0_rdata, fp_p1_rdata, fp_address, fp_in;
    logic       fp_p0_ready, fp_p1_ready, fp_rd, fp_wr, fp_busy, fp_timeout;
    logic [1:0] fp_grant;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ready(p0_ready),
        .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ready(p1_ready),
        .memory_address(memory_address), .memory_in(memory_in),
        .memory_read_signal(memory_read_signal), .memory_write_signal(memory_write_signal),
        .memory_out(memory_out), .memory_ready(memory_ready),
        .grant(grant), .busy(busy), .timeout_error(timeout_error)
    );

    mem_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address), .p0_wdata(p0_wdata),
        .p0_rdata(fp_p0_rdata), .p0_ready(fp_p0_ready),
        .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address), .p1_wdata(p1_wdata),
        .p1_rdata(fp_p1_rdata), .p1_ready(fp_p1_ready),
        .memory_address(fp_address), .memory_in(fp_in),
        .memory_read_signal(fp_rd), .memory_write_signal(fp_wr),
        .memory_out(memory_out), .memory_ready(memory_ready),
        .grant(fp_grant), .busy(fp_busy), .timeout_error(fp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    logic [1:0] rr_exp [4];

    initial begin
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        rst_n = 1'b0;
        p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
        p0_address = 0; p0_wdata = 0; p1_address = 0; p1_wdata = 0;
        memory_out = 0; memory_ready = 0;
        repeat (2) cyc();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd", 32'(memory_read_signal), 0);
        chk("rst_wr", 32'(memory_write_signal), 0);
        chk("rst_addr", 32'(memory_address), 0);
        chk("rst_in", 32'(memory_in), 0);
        chk("rst_tmo", 32'(timeout_error), 0);
        rst_n = 1'b1;
        cyc();

        // stray memory_ready while idle
        memory_ready = 1; memory_out = 8'h77; #1;
        chk("idle_ready_p0", 32'(p0_ready), 0);
        chk("idle_ready_p1", 32'(p1_ready), 0);
        chk("idle_rdata_p0", 32'(p0_rdata), 0);
        memory_ready = 0;
        cyc();

        // 1: single read
        p0_read = 1; p0_address = 8'h20; #1;
        chk("t1_no_strobe_yet", 32'(memory_read_signal), 0);
        cyc();
        chk("t1_rd", 32'(memory_read_signal), 1);
        chk("t1_wr", 32'(memory_write_signal), 0);
        chk("t1_addr", 32'(memory_address), 32'h20);
        chk("t1_grant", 32'(grant), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_early_ready", 32'(p0_ready), 0);
        cyc();
        cyc();
        chk("t1_rd_held", 32'(memory_read_signal), 1);
        memory_ready = 1; memory_out = 8'h5A; #1;
        chk("t1_p0_ready", 32'(p0_ready), 1);
        chk("t1_p0_rdata", 32'(p0_rdata), 32'h5A);
        chk("t1_p1_ready", 32'(p1_ready), 0);
        chk("t1_p1_rdata", 32'(p1_rdata), 0);
        chk("t1_tmo", 32'(timeout_error), 0);
        cyc();
        p0_read = 0; memory_ready = 0; #1;
        chk("t1_idle_grant", 32'(grant), 0);
        chk("t1_idle_rd", 32'(memory_read_signal), 0);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_p0_ready_gone", 32'(p0_ready), 0);

        // 2: simultaneous writes from reset
        do_reset();
        p0_write = 1; p0_address = 8'h10; p0_wdata = 8'hA1;
        p1_write = 1; p1_address = 8'h11; p1_wdata = 8'hB2;
        cyc();
        chk("t2_grant_a", 32'(grant), 1);
        chk("t2_wr_a", 32'(memory_write_signal), 1);
        chk("t2_rd_a", 32'(memory_read_signal), 0);
        chk("t2_addr_a", 32'(memory_address), 32'h10);
        chk("t2_in_a", 32'(memory_in), 32'hA1);
        memory_ready = 1; #1;
        chk("t2_p0_ready", 32'(p0_ready), 1);
        chk("t2_p1_not_ready", 32'(p1_ready), 0);
        cyc();
        p0_write = 0; memory_ready = 0; #1;
        chk("t2_gap_grant", 32'(grant), 0);
        cyc();
        chk("t2_grant_b", 32'(grant), 2);
        chk("t2_addr_b", 32'(memory_address), 32'h11);
        chk("t2_in_b", 32'(memory_in), 32'hB2);
        chk("t2_wr_b", 32'(memory_write_signal), 1);
        memory_ready = 1; #1;
        chk("t2_p1_ready", 32'(p1_ready), 1);
        chk("t2_p0_not_ready", 32'(p0_ready), 0);
        cyc();
        p1_write = 0; memory_ready = 0;

        // 3: continuous contention; round-robin vs fixed priority
        p0_read = 1; p1_read = 1; p0_address = 8'h01; p1_address = 8'h02;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("t3_rr_grant%0d", i), 32'(grant), 32'(rr_exp[i]));
            chk($sformatf("t3_fp_grant%0d", i), 32'(fp_grant), 1);
            memory_ready = 1; memory_out = 8'(8'h30 + i); #1;
            if (rr_exp[i] == 2'b01) chk($sformatf("t3_p0_rdy%0d", i), 32'(p0_ready), 1);
            else                    chk($sformatf("t3_p1_rdy%0d", i), 32'(p1_ready), 1);
            cyc();
            memory_ready = 0; #1;
            chk($sformatf("t3_gap%0d", i), 32'(grant), 0);
        end
        p0_read = 0; p1_read = 0;
        cyc();

        // 4: watchdog abort, then the queued port proceeds
        p0_read = 1; p0_address = 8'h33; p1_read = 1; p1_address = 8'h44; memory_out = 8'h12;
        cyc();
        chk("t4_grant", 32'(grant), 1);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("t4_no_tmo%0d", i), 32'(timeout_error), 0);
            chk($sformatf("t4_no_rdy%0d", i), 32'(p0_ready), 0);
            cyc();
        end
        chk("t4_busy_16", 32'(busy), 1);
        chk("t4_tmo", 32'(timeout_error), 1);
        chk("t4_p0_ready", 32'(p0_ready), 1);
        chk("t4_p0_rdata", 32'(p0_rdata), 32'hFF);
        chk("t4_p1_ready", 32'(p1_ready), 0);
        chk("t4_fp_tmo", 32'(fp_timeout), 1);
        cyc();
        p0_read = 0; #1;
        chk("t4_tmo_pulse", 32'(timeout_error), 0);
        chk("t4_idle", 32'(grant), 0);
        cyc();
        chk("t4_next_grant", 32'(grant), 2);
        chk("t4_next_addr", 32'(memory_address), 32'h44);
        memory_ready = 1; memory_out = 8'h9C; #1;
        chk("t4_p1_ready", 32'(p1_ready), 1);
        chk("t4_p1_rdata", 32'(p1_rdata), 32'h9C);
        chk("t4_no_tmo_after", 32'(timeout_error), 0);
        cyc();
        p1_read = 0; memory_ready = 0;
        cyc();

        // 5: address change after grant is ignored
        p1_read = 1; p1_address = 8'h40;
        cyc();
        chk("t5_addr", 32'(memory_address), 32'h40);
        p1_address = 8'h41;
        cyc();
        chk("t5_addr_held", 32'(memory_address), 32'h40);
        memory_ready = 1; memory_out = 8'h66; #1;
        chk("t5_p1_rdata", 32'(p1_rdata), 32'h66);
        cyc();
        p1_read = 0; memory_ready = 0;
        cyc();

        // owner drops its strobe mid-transaction; bus still completes
        p0_read = 1; p0_address = 8'h50;
        cyc();
        p0_read = 0;
        cyc();
        chk("drop_busy", 32'(busy), 1);
        chk("drop_rd", 32'(memory_read_signal), 1);
        memory_ready = 1; memory_out = 8'h3C; #1;
        chk("drop_ready", 32'(p0_ready), 1);
        cyc();
        memory_ready = 0;
        cyc();

        // 6: reset mid-BUSY
        p0_write = 1; p0_address = 8'h60; p0_wdata = 8'hC3;
        cyc();
        chk("t6_wr", 32'(memory_write_signal), 1);
        rst_n = 0; memory_ready = 1; #1;
        chk("t6_rst_wr", 32'(memory_write_signal), 0);
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_ready", 32'(p0_ready), 0);
        cyc();
        rst_n = 1; memory_ready = 0;
        cyc();
        chk("t6_regrant", 32'(grant), 1);
        chk("t6_addr", 32'(memory_address), 32'h60);
        chk("t6_in", 32'(memory_in), 32'hC3);
        memory_ready = 1; #1;
        chk("t6_ready", 32'(p0_ready), 1);
        cyc();
        p0_write = 0; memory_ready = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
